bit_serial_adder: RTL

//   Multi-cycle WIDTH-bit adder built around one 1-bit full-adder cell
//   (sum = a^b^cin, cout = a&b | cin&(a^b)).

---
 rtl/bit_serial_adder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder_fa
// Brief    : Single-bit full-adder cell used by the serial adder datapath.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Pure combinational sum and carry of one bit position
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// ============================================================================
// Module   : bit_serial_adder
// Brief    : Multi-cycle WIDTH-bit unsigned adder. Operands are captured on an
//            accepted start and streamed LSB-first through one full-adder cell,
//            with the carry held in a flop between bit-cycles. The result
//            register only changes on a completion edge or on reset.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Counter width: one count per bit-cycle, 0..WIDTH-1
    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // State encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;

    logic               w_fa_s;
    logic               w_fa_cout;
    logic               w_accept;
    logic               w_running;
    logic               w_last_bit;
    logic [WIDTH-1:0]   w_res_next;

    // The only arithmetic element: one full-adder fed by the shift-register LSBs
    bit_serial_adder_fa u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    // Control decodes shared by the FSM and the datapath
    always_comb begin
        w_accept   = start && ((r_state == c_IDLE) || (r_state == c_DONE));
        w_running  = (r_state == c_RUN);
        w_last_bit = w_running && (r_cnt == c_LAST);
        // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
        w_res_next = {w_fa_s, r_res_sh[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE always lasts one cycle and can chain into RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  w_state_next = start ? c_RUN : c_IDLE;
            c_RUN:   w_state_next = (r_cnt == c_LAST) ? c_DONE : c_RUN;
            c_DONE:  w_state_next = start ? c_RUN : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Status outputs decode the registered state only
    always_comb begin
        busy = (r_state == c_RUN);
        done = (r_state == c_DONE);
    end

    // Datapath: capture operands on accept, shift one bit per RUN cycle,
    // publish the result only on the final bit-cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_c_out  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
        end else if (w_running) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_carry  <= w_fa_cout;
            r_cnt    <= r_cnt + c_ONE;
            r_res_sh <= w_res_next;
            if (w_last_bit) begin
                r_sum   <= w_res_next;
                r_c_out <= w_fa_cout;
            end
        end
    end

    // Result outputs come straight from the holding registers
    always_comb begin
        sum   = r_sum;
        c_out = r_c_out;
    end

endmodule
`default_nettype wire
